// File: rtl/vdma_pkg.sv
// Shared definitions for the video capture to VDMA write path: FSM states,
// start latency after vsync fall, and line-length arithmetic.
package vdma_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WAIT_DE = 3'd2,
    ACTIVE  = 3'd3,
    TAIL    = 3'd4,
    FEND    = 3'd5
  } state_e;

  localparam int START_LAT = 4;

  // Words needed to hold one line, rounding a partial tail word up.
  function automatic logic [23:0] words_per_line(input logic [23:0] width, input int ppw);
    logic [24:0] sum;
    sum = {1'b0, width} + 25'(ppw - 1);
    return 24'(sum / 25'(ppw));
  endfunction

endpackage

// File: rtl/video_pack_in_pix_lane_packer.sv
// Packs pixels into bus words, lane 0 in the MSBs; emits a full word or a
// zero-padded tail word with matching byte enables one cycle after the push.
module pix_lane_packer #(
  parameter int PIX_BITS = 16,
  parameter int BUS_BITS = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  abort_i,
  input  logic                  push_i,
  input  logic                  last_i,
  input  logic [PIX_BITS-1:0]   pix_i,
  output logic                  wr_en_o,
  output logic [BUS_BITS-1:0]   wr_data_o,
  output logic [BUS_BITS/8-1:0] wr_be_o
);

  localparam int PPW    = BUS_BITS / PIX_BITS;
  localparam int NB     = BUS_BITS / 8;
  localparam int BPP    = PIX_BITS / 8;
  localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;

  logic [BUS_BITS-1:0] word_q;
  logic [LANE_W-1:0]   lane_q;
  logic [BUS_BITS-1:0] word_ins;
  logic [NB-1:0]       be_ins;
  logic                wr_en_q;
  logic [BUS_BITS-1:0] wr_data_q;
  logic [NB-1:0]       wr_be_q;

  always_comb begin
    word_ins = word_q;
    be_ins   = '0;
    for (int k = 0; k < PPW; k++) begin
      if (lane_q == LANE_W'(k)) word_ins[BUS_BITS-1-k*PIX_BITS -: PIX_BITS] = pix_i;
      if (LANE_W'(k) <= lane_q) be_ins[NB-1-k*BPP -: BPP] = '1;
    end
  end

  // Abort drops any partially filled word so the next frame starts at lane 0.
  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      word_q    <= '0;
      lane_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (push_i) begin
        if (lane_q == LANE_W'(PPW - 1) || last_i) begin
          wr_en_q   <= 1'b1;
          wr_data_q <= word_ins;
          wr_be_q   <= be_ins;
          word_q    <= '0;
          lane_q    <= '0;
        end else begin
          word_q <= word_ins;
          lane_q <= lane_q + LANE_W'(1);
        end
      end
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_data_o = wr_data_q;
  assign wr_be_o   = wr_be_q;

endmodule

// File: rtl/video_pack_in.sv
// Video capture front end: frame/line sequencing, DDR write-master setup and
// pixel packing into VDMA FIFO words.
module video_pack_in
  import vdma_pkg::*;
#(
  parameter int    ADDR_BITS    = 25,
  parameter int    PIX_BITS     = 16,
  parameter int    BUS_BITS     = 64,
  parameter string BROADEN_LOAD = "FALSE",
  parameter int    LOAD_CYC     = 6
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  vsync,
  input  logic                  de,
  input  logic [PIX_BITS-1:0]   indata,
  input  logic [ADDR_BITS-1:0]  baseaddr,
  input  logic [23:0]           video_width,
  input  logic [11:0]           video_height,
  input  logic                  sync_fifo_empty,
  output logic                  fifo_empty,
  output logic                  wr_fifo_en,
  output logic [BUS_BITS-1:0]   wr_data,
  output logic [BUS_BITS/8-1:0] wr_be,
  output logic                  arst_fifo,
  output logic                  loadbase,
  output logic [ADDR_BITS-1:0]  ddr_baseaddr,
  output logic [23:0]           ddr_line_length,
  output logic [11:0]           ddr_col_length,
  output logic                  frame_done,
  output logic                  line_over_err,
  output logic [2:0]            dbg_state_o
);

  localparam int PPW      = BUS_BITS / PIX_BITS;
  localparam int LOAD_LEN = (BROADEN_LOAD == "TRUE") ? LOAD_CYC : 1;

  state_e                 state_q;
  logic                   vsync_q;
  logic [START_LAT-1:0]   start_sr_q;
  logic [7:0]             load_cnt_q;
  logic [23:0]            width_q, pix_cnt_q;
  logic [11:0]            height_q, line_cnt_q;
  logic                   line_full_q;
  logic                   arst_q, loadbase_q, frame_done_q, err_q;
  logic [ADDR_BITS-1:0]   base_q;
  logic [23:0]            line_len_q;
  logic                   vsync_rise, vsync_fall, accept, last;

  assign vsync_rise = vsync & ~vsync_q;
  assign vsync_fall = ~vsync & vsync_q;
  assign accept     = de && !line_full_q && !vsync_rise &&
                      (state_q == WAIT_DE || state_q == ACTIVE);
  assign last       = (pix_cnt_q + 24'd1) == width_q;

  // line_full_q marks the rest of a completed de run: such pixels are dropped.
  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q      <= IDLE;
      vsync_q      <= 1'b0;
      start_sr_q   <= '0;
      load_cnt_q   <= '0;
      width_q      <= '0;
      height_q     <= '0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      line_full_q  <= 1'b0;
      arst_q       <= 1'b0;
      loadbase_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      base_q       <= '0;
      line_len_q   <= '0;
    end else begin
      vsync_q      <= vsync;
      frame_done_q <= 1'b0;
      start_sr_q   <= {start_sr_q[START_LAT-2:0], vsync_fall};
      if (vsync_fall) begin
        base_q     <= baseaddr;
        width_q    <= video_width;
        height_q   <= video_height;
        line_len_q <= words_per_line(video_width, PPW);
      end
      if (!de) line_full_q <= 1'b0;
      if (de && line_full_q) err_q <= 1'b1;
      if (vsync_rise) begin
        state_q    <= IDLE;
        start_sr_q <= '0;
        arst_q     <= 1'b0;
        loadbase_q <= 1'b0;
        pix_cnt_q  <= '0;
      end else begin
        case (state_q)
          IDLE: if (start_sr_q[START_LAT-1]) begin
            state_q     <= LOAD;
            load_cnt_q  <= 8'(LOAD_LEN - 1);
            arst_q      <= 1'b1;
            loadbase_q  <= 1'b1;
            err_q       <= 1'b0;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            line_full_q <= 1'b0;
          end
          LOAD: begin
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
            if (load_cnt_q == 8'd0) begin
              arst_q     <= 1'b0;
              loadbase_q <= 1'b0;
              if (width_q == 24'd0 || height_q == 12'd0) begin
                state_q      <= FEND;
                frame_done_q <= 1'b1;
              end else begin
                state_q <= WAIT_DE;
              end
            end else begin
              load_cnt_q <= load_cnt_q - 8'd1;
            end
          end
          WAIT_DE, ACTIVE: if (accept) begin
            pix_cnt_q <= pix_cnt_q + 24'd1;
            if (last) begin
              state_q     <= TAIL;
              line_full_q <= 1'b1;
            end else begin
              state_q <= ACTIVE;
            end
          end
          TAIL: begin
            pix_cnt_q  <= '0;
            line_cnt_q <= line_cnt_q + 12'd1;
            if (line_cnt_q + 12'd1 == height_q) begin
              state_q      <= FEND;
              frame_done_q <= 1'b1;
            end else begin
              state_q <= WAIT_DE;
            end
          end
          FEND:    state_q <= FEND;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // wr_fifo_en is a push-only strobe with no backpressure: each word is offered exactly once.
  pix_lane_packer #(
    .PIX_BITS(PIX_BITS),
    .BUS_BITS(BUS_BITS)
  ) u_packer (
    .clk_i    (pclk),
    .rst_i    (prst),
    .abort_i  (vsync_rise),
    .push_i   (accept),
    .last_i   (last),
    .pix_i    (indata),
    .wr_en_o  (wr_fifo_en),
    .wr_data_o(wr_data),
    .wr_be_o  (wr_be)
  );

  assign fifo_empty      = sync_fifo_empty;
  assign arst_fifo       = arst_q;
  assign loadbase        = loadbase_q;
  assign ddr_baseaddr    = base_q;
  assign ddr_line_length = line_len_q;
  assign ddr_col_length  = height_q;
  assign frame_done      = frame_done_q;
  assign line_over_err   = err_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_video_pack_in.sv
// Directed bench for video_pack_in: three instances (16b/64b, 8b/64b,
// 16b/64b with broadened LOAD) share the stimulus; one is scored per test.
module tb_video_pack_in;

  // ---------------- clock / reset ----------------
  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        prst, vsync, de, sync_fifo_empty;
  logic [15:0] indata16;
  logic [7:0]  indata8;
  logic [24:0] baseaddr;
  logic [23:0] video_width;
  logic [11:0] video_height;

  logic        fe_a, wen_a, arst_a, load_a, fd_a, err_a;
  logic [63:0] wdat_a;
  logic [7:0]  wbe_a;
  logic [24:0] dbase_a;
  logic [23:0] dlen_a;
  logic [11:0] dcol_a;
  logic [2:0]  st_a;

  logic        fe_b, wen_b, arst_b, load_b, fd_b, err_b;
  logic [63:0] wdat_b;
  logic [7:0]  wbe_b;
  logic [24:0] dbase_b;
  logic [23:0] dlen_b;
  logic [11:0] dcol_b;
  logic [2:0]  st_b;

  logic        fe_c, wen_c, arst_c, load_c, fd_c, err_c;
  logic [63:0] wdat_c;
  logic [7:0]  wbe_c;
  logic [24:0] dbase_c;
  logic [23:0] dlen_c;
  logic [11:0] dcol_c;
  logic [2:0]  st_c;

  video_pack_in #(.PIX_BITS(16), .BUS_BITS(64)) dut_a (
    .pclk(pclk), .prst(prst), .vsync(vsync), .de(de), .indata(indata16),
    .baseaddr(baseaddr), .video_width(video_width), .video_height(video_height),
    .sync_fifo_empty(sync_fifo_empty), .fifo_empty(fe_a), .wr_fifo_en(wen_a),
    .wr_data(wdat_a), .wr_be(wbe_a), .arst_fifo(arst_a), .loadbase(load_a),
    .ddr_baseaddr(dbase_a), .ddr_line_length(dlen_a), .ddr_col_length(dcol_a),
    .frame_done(fd_a), .line_over_err(err_a), .dbg_state_o(st_a)
  );

  video_pack_in #(.PIX_BITS(8), .BUS_BITS(64)) dut_b (
    .pclk(pclk), .prst(prst), .vsync(vsync), .de(de), .indata(indata8),
    .baseaddr(baseaddr), .video_width(video_width), .video_height(video_height),
    .sync_fifo_empty(sync_fifo_empty), .fifo_empty(fe_b), .wr_fifo_en(wen_b),
    .wr_data(wdat_b), .wr_be(wbe_b), .arst_fifo(arst_b), .loadbase(load_b),
    .ddr_baseaddr(dbase_b), .ddr_line_length(dlen_b), .ddr_col_length(dcol_b),
    .frame_done(fd_b), .line_over_err(err_b), .dbg_state_o(st_b)
  );

  video_pack_in #(.PIX_BITS(16), .BUS_BITS(64), .BROADEN_LOAD("TRUE"), .LOAD_CYC(6)) dut_c (
    .pclk(pclk), .prst(prst), .vsync(vsync), .de(de), .indata(indata16),
    .baseaddr(baseaddr), .video_width(video_width), .video_height(video_height),
    .sync_fifo_empty(sync_fifo_empty), .fifo_empty(fe_c), .wr_fifo_en(wen_c),
    .wr_data(wdat_c), .wr_be(wbe_c), .arst_fifo(arst_c), .loadbase(load_c),
    .ddr_baseaddr(dbase_c), .ddr_line_length(dlen_c), .ddr_col_length(dcol_c),
    .frame_done(fd_c), .line_over_err(err_c), .dbg_state_o(st_c)
  );

  // ---------------- scoreboard ----------------
  logic [71:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int sel      = 0;
  int cyc      = 0;
  int wr_cnt, fd_cnt, ld_a, ld_c, last_wr_cyc, fd_cyc;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    logic        en_s, fd_s;
    logic [71:0] w_s, e_s;
    case (sel)
      1:       begin en_s = wen_b; fd_s = fd_b; w_s = {wbe_b, wdat_b}; end
      2:       begin en_s = wen_c; fd_s = fd_c; w_s = {wbe_c, wdat_c}; end
      default: begin en_s = wen_a; fd_s = fd_a; w_s = {wbe_a, wdat_a}; end
    endcase
    if (en_s) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      check("wr_pending", 72'(exp_q.size() != 0), 72'd1);
      if (exp_q.size() != 0) begin
        e_s = exp_q.pop_front();
        check("wr_word", w_s, e_s);
      end
    end
    if (fd_s) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
    if (arst_a && load_a) ld_a++;
    if (arst_c && load_c) ld_c++;
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts(input int s);
    sel    = s;
    wr_cnt = 0;
    fd_cnt = 0;
    ld_a   = 0;
    ld_c   = 0;
    exp_q.delete();
  endtask

  // Frame parameters are valid at vsync fall; baseaddr changes right after.
  task automatic start_frame(input logic [24:0] base, input logic [23:0] w, input logic [11:0] h);
    vsync = 1'b1;
    repeat (2) @(negedge pclk);
    baseaddr = base; video_width = w; video_height = h; vsync = 1'b0;
    @(negedge pclk);
    baseaddr = ~base;
    repeat (13) @(negedge pclk);
  endtask

  task automatic send_pixels(input int n, input int gap, input logic [15:0] seed);
    for (int i = 0; i < n; i++) begin
      de = 1'b1;
      indata16 = seed + 16'(i);
      indata8  = 8'(seed + 16'(i));
      @(negedge pclk);
      if (gap > 0) begin
        de = 1'b0;
        repeat (gap) @(negedge pclk);
      end
    end
    de = 1'b0;
    repeat (3) @(negedge pclk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  // ---------------- directed tests ----------------
  initial begin
    prst = 1'b1; vsync = 1'b0; de = 1'b0; indata16 = '0; indata8 = '0;
    baseaddr = '0; video_width = '0; video_height = '0; sync_fifo_empty = 1'b1;
    clear_counts(0);
    repeat (2) @(negedge pclk);
    prst = 1'b0;
    @(negedge pclk);

    check("rst_state", st_a, 3'd0);
    check("rst_wr_en", wen_a, 1'b0);
    check("rst_wr_be", wbe_a, 8'h00);
    check("rst_arst", arst_a, 1'b0);
    check("rst_loadbase", load_a, 1'b0);
    check("rst_base", dbase_a, 25'd0);
    check("rst_frame_done", fd_a, 1'b0);
    check("rst_fifo_empty1", fe_a, 1'b1);
    sync_fifo_empty = 1'b0;
    @(negedge pclk);
    check("rst_fifo_empty0", fe_a, 1'b0);

    // 16b/64b, 8x2 continuous
    clear_counts(0);
    exp_q.push_back(72'hFF_1000_1001_1002_1003);
    exp_q.push_back(72'hFF_1004_1005_1006_1007);
    exp_q.push_back(72'hFF_2000_2001_2002_2003);
    exp_q.push_back(72'hFF_2004_2005_2006_2007);
    start_frame(25'h0123456, 24'd8, 12'd2);
    check("t1_load_cycles", ld_a, 1);
    check("t1_base", dbase_a, 25'h0123456);
    check("t1_line_len", dlen_a, 24'd2);
    check("t1_col_len", dcol_a, 12'd2);
    check("t1_wait_de", st_a, 3'd2);
    send_pixels(8, 0, 16'h1000);
    send_pixels(8, 0, 16'h2000);
    check("t1_writes", wr_cnt, 4);
    check("t1_exp_left", exp_q.size(), 0);
    check("t1_frame_done", fd_cnt, 1);
    check("t1_fd_latency", fd_cyc - last_wr_cyc, 1);
    check("t1_fend", st_a, 3'd5);
    check("t1_no_err", err_a, 1'b0);

    // 16b/64b, width 6 tail word
    clear_counts(0);
    exp_q.push_back(72'hFF_3000_3001_3002_3003);
    exp_q.push_back(72'hF0_3004_3005_0000_0000);
    start_frame(25'h0000100, 24'd6, 12'd1);
    check("t2_line_len", dlen_a, 24'd2);
    send_pixels(6, 0, 16'h3000);
    check("t2_writes", wr_cnt, 2);
    check("t2_frame_done", fd_cnt, 1);

    // 8b/64b, width 8 with 3-cycle gaps, then continuous
    clear_counts(1);
    exp_q.push_back(72'hFF_4041424344454647);
    start_frame(25'h0000200, 24'd8, 12'd1);
    check("t3_line_len", dlen_b, 24'd1);
    send_pixels(8, 3, 16'h0040);
    check("t3_gap_writes", wr_cnt, 1);
    clear_counts(1);
    exp_q.push_back(72'hFF_4041424344454647);
    start_frame(25'h0000200, 24'd8, 12'd1);
    send_pixels(8, 0, 16'h0040);
    check("t3_cont_writes", wr_cnt, 1);

    // overlong line: width 4, 6 pixels
    clear_counts(0);
    exp_q.push_back(72'hFF_5000_5001_5002_5003);
    start_frame(25'h0000300, 24'd4, 12'd1);
    send_pixels(6, 0, 16'h5000);
    check("t4_writes", wr_cnt, 1);
    check("t4_over_err", err_a, 1'b1);

    // next frame clears the error; vsync mid-line discards the partial word
    clear_counts(0);
    start_frame(25'h0000400, 24'd4, 12'd1);
    check("t5_err_cleared", err_a, 1'b0);
    send_pixels(2, 0, 16'h6000);
    start_frame(25'h0000500, 24'd4, 12'd1);
    check("t5_abort_no_wr", wr_cnt, 0);
    exp_q.push_back(72'hFF_7000_7001_7002_7003);
    send_pixels(4, 0, 16'h7000);
    check("t5_clean_writes", wr_cnt, 1);

    // broadened LOAD on the third instance
    clear_counts(2);
    exp_q.push_back(72'hFF_8000_8001_8002_8003);
    start_frame(25'h1ABCDE, 24'd4, 12'd1);
    check("t6_load_cycles", ld_c, 6);
    check("t6_base_latched", dbase_c, 25'h1ABCDE);
    send_pixels(4, 0, 16'h8000);
    check("t6_writes", wr_cnt, 1);

    // zero width: LOAD straight to FEND
    clear_counts(0);
    start_frame(25'h0000600, 24'd0, 12'd3);
    check("t7_frame_done", fd_cnt, 1);
    check("t7_fend", st_a, 3'd5);
    send_pixels(4, 0, 16'h9100);
    check("t7_no_writes", wr_cnt, 0);

    // reset while ACTIVE
    clear_counts(0);
    start_frame(25'h1555555, 24'd8, 12'd1);
    de = 1'b1; indata16 = 16'h9000; indata8 = 8'h00;
    @(negedge pclk);
    indata16 = 16'h9001;
    @(negedge pclk);
    de = 1'b0;
    @(negedge pclk);
    check("t8_active", st_a, 3'd3);
    prst = 1'b1;
    @(negedge pclk);
    prst = 1'b0;
    check("t8_state", st_a, 3'd0);
    check("t8_base", dbase_a, 25'd0);
    check("t8_line_len", dlen_a, 24'd0);
    check("t8_col_len", dcol_a, 12'd0);
    check("t8_wr_data", wdat_a, 64'd0);
    check("t8_wr_en", wen_a, 1'b0);
    send_pixels(6, 0, 16'h9002);
    check("t8_no_writes", wr_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
